// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LUT layer: one FANIN-input LUT evaluated for each neuron in turn,
// with truth tables and connectivity held in distributed RAM loaded through a config port.
module lut_layer_sequencer #(
  parameter int IN_WIDTH    = 64,
  parameter int NUM_NEURONS = 16,
  parameter int FANIN       = 8,
  parameter int IDX_W       = $clog2(IN_WIDTH),
  parameter int NID_W       = $clog2(NUM_NEURONS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IN_WIDTH-1:0]        in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_NEURONS-1:0]     out_data_o,
  input  logic                       cfg_tt_we_i,
  input  logic [NID_W-1:0]           cfg_tt_neuron_i,
  input  logic [FANIN-1:0]           cfg_tt_addr_i,
  input  logic                       cfg_tt_bit_i,
  input  logic                       cfg_map_we_i,
  input  logic [NID_W-1:0]           cfg_map_neuron_i,
  input  logic [$clog2(FANIN)-1:0]   cfg_map_slot_i,
  input  logic [IDX_W-1:0]           cfg_map_idx_i,
  output logic                       cfg_err_o,
  output logic                       busy_o
);
  localparam int DEPTH = 1 << FANIN;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

  state_e                 state_q, state_d;
  logic [NID_W-1:0]       k_q, k_d;
  logic [IN_WIDTH-1:0]    in_q, in_d;
  logic [NUM_NEURONS-1:0] out_q, out_d;
  logic                   err_q, err_d;

  // RAM contents deliberately survive reset.
  logic [DEPTH-1:0]       tt_mem  [NUM_NEURONS];
  logic [IDX_W-1:0]       map_mem [NUM_NEURONS][FANIN];

  logic                   tt_ok, map_ok;
  logic [FANIN-1:0]       lut_addr;
  logic                   lut_bit;

  assign tt_ok  = cfg_tt_we_i && (state_q == IDLE) &&
                  (int'(cfg_tt_neuron_i) < NUM_NEURONS);
  assign map_ok = cfg_map_we_i && (state_q == IDLE) &&
                  (int'(cfg_map_neuron_i) < NUM_NEURONS) &&
                  (int'(cfg_map_idx_i) < IN_WIDTH);
  assign err_d  = (cfg_tt_we_i && !tt_ok) || (cfg_map_we_i && !map_ok);

  always_ff @(posedge clk_i) begin
    if (tt_ok)  tt_mem[cfg_tt_neuron_i][cfg_tt_addr_i] <= cfg_tt_bit_i;
    if (map_ok) map_mem[cfg_map_neuron_i][cfg_map_slot_i] <= cfg_map_idx_i;
  end

  // Gather the selected input bits for neuron k; slot 0 drives the LUT address LSB.
  always_comb begin
    lut_addr = '0;
    for (int j = 0; j < FANIN; j++) lut_addr[j] = in_q[map_mem[k_q][j]];
    lut_bit = tt_mem[k_q][lut_addr];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    in_d    = in_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = EVAL;
        k_d     = '0;
        in_d    = in_data_i;
      end
      EVAL: begin
        out_d[k_q] = lut_bit;
        if (k_q == NID_W'(NUM_NEURONS - 1)) state_d = DONE;
        else k_d = k_q + NID_W'(1);
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      in_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      in_q    <= in_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = out_q;
  assign cfg_err_o   = err_q;
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Randomized scoreboard bench for lut_layer_sequencer against a table-lookup reference model.
module tb_lut_layer_sequencer;
  localparam int IW = 64, NN = 16, FI = 8, IDXW = 6, NIDW = 4, SW = 3, DEPTH = 256;

  logic            clk = 0, rst = 1;
  logic            in_valid = 0, out_ready = 1;
  logic [IW-1:0]   in_data = '0;
  logic            in_ready, out_valid, cfg_err, busy;
  logic [NN-1:0]   out_data;
  logic            tt_we = 0, tt_bit = 0, map_we = 0;
  logic [NIDW-1:0] tt_n = '0, map_n = '0;
  logic [FI-1:0]   tt_a = '0;
  logic [SW-1:0]   map_s = '0;
  logic [IDXW-1:0] map_i = '0;

  lut_layer_sequencer dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .cfg_tt_we_i(tt_we), .cfg_tt_neuron_i(tt_n),
    .cfg_tt_addr_i(tt_a), .cfg_tt_bit_i(tt_bit), .cfg_map_we_i(map_we),
    .cfg_map_neuron_i(map_n), .cfg_map_slot_i(map_s), .cfg_map_idx_i(map_i),
    .cfg_err_o(cfg_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit            tt_m  [NN][DEPTH];
  int            map_m [NN][FI];
  logic [NN-1:0] exp_q [$];
  int            lat_q [$];
  int            total = 0, bad = 0;
  bit            b2b = 0;
  int            last_acc = -1;
  logic          prev_ov = 0;

  // Each neuron: build the LUT address from the mapped input bits, then look up its table.
  function automatic logic [NN-1:0] model(input logic [IW-1:0] x);
    logic [NN-1:0] r;
    int a;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      a = 0;
      for (int j = 0; j < FI; j++) if (x[map_m[n][j]]) a += (1 << j);
      r[n] = tt_m[n][a];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Accept tap: the expected vector is computed when the input is taken.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(in_data));
      lat_q.push_back(cyc + 1);
      if (b2b && last_acc >= 0) chk("b2b_period", 64'(cyc + 1 - last_acc), 64'(NN + 2));
      last_acc = cyc + 1;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rst) prev_ov = 0;
    else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) fail("latency_no_accept");
        else chk("latency", 64'(cyc - lat_q.pop_front()), 64'(NN));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) begin
        tt_we = 1; tt_n = NIDW'(n); tt_a = FI'(a); tt_bit = tt_m[n][a];
        map_we = (a < FI); map_n = NIDW'(n); map_s = SW'(a % FI); map_i = IDXW'(map_m[n][a % FI]);
        tick();
      end
    tt_we = 0; map_we = 0;
  endtask

  task automatic send(input logic [IW-1:0] v, input bit hold);
    int g = 0;
    in_valid = 1; in_data = v;
    while (!in_ready && g < 200) begin tick(); g++; end
    if (g >= 200) fail("send_timeout");
    tick();
    if (!hold) in_valid = 0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin tick(); g++; end
    if (g >= 500) fail("drain_timeout");
  endtask

  function automatic logic [IW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] v, v2;
    logic [NN-1:0] ev;
    int g, a;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 1); chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0); chk("rst_cfg_err", 64'(cfg_err), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 0; tick();

    // Identity neuron: neuron 0 reports input bit 5.
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++) begin
        tt_m[n][i] = (n == 0) ? i[5] : 1'b0;
        if (i < FI) map_m[n][i] = (n == 0) ? i : 0;
      end
    load_all();
    chk("cfg_err_idle", 64'(cfg_err), 0);
    chk("model_identity", 64'(model(64'h20)), 64'h0001);
    send(64'h20, 0); drain();
    chk("identity_hold", 64'(out_data), 64'h0001);
    send(64'h0, 0); drain();
    chk("identity_zero", 64'(out_data), 64'h0000);

    // Full layer: neuron n is an 8-way AND of input bit n.
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++) begin
        tt_m[n][i] = (i == 255);
        if (i < FI) map_m[n][i] = n;
      end
    load_all();
    send(64'h00A5, 0); drain();
    chk("full_layer", 64'(out_data), 64'h00A5);
    for (int i = 0; i < 3; i++) begin send(rnd64(), 0); drain(); end

    // Random tables and connectivity.
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++) begin
        tt_m[n][i] = $urandom_range(0, 1);
        if (i < FI) map_m[n][i] = $urandom_range(0, IW - 1);
      end
    load_all();
    for (int i = 0; i < 4; i++) begin send(rnd64(), 0); drain(); end

    // Output stall with the next vector waiting.
    v = rnd64(); v2 = rnd64(); ev = model(v);
    out_ready = 0;
    send(v, 0);
    in_valid = 1; in_data = v2;
    g = 0;
    while (!out_valid && g < 100) begin tick(); g++; end
    if (g >= 100) fail("stall_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_data", 64'(out_data), 64'(ev));
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_in_ready", 64'(in_ready), 0);
      tick();
    end
    out_ready = 1;
    send(v2, 0); drain();

    // Config during EVAL is rejected and leaves the tables unchanged.
    v = rnd64();
    send(v, 0);
    chk("busy_eval", 64'(busy), 1);
    a = $urandom_range(0, DEPTH - 1);
    tt_we = 1; tt_n = 3; tt_a = FI'(a); tt_bit = ~tt_m[3][a];
    map_we = 1; map_n = 3; map_s = 0; map_i = IDXW'((map_m[3][0] + 1) % IW);
    tick();
    tt_we = 0; map_we = 0;
    chk("cfg_err_pulse", 64'(cfg_err), 1);
    tick();
    chk("cfg_err_clear", 64'(cfg_err), 0);
    drain();
    send(v, 0); drain();
    chk("rerun_same", 64'(out_data), 64'(model(v)));

    // Reset mid-evaluation.
    send(rnd64(), 0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1; #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    chk("mid_rst_out_data", 64'(out_data), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    exp_q.delete(); lat_q.delete();
    tick(); rst = 0; tick();
    send(rnd64(), 0); drain();

    // Back-to-back vectors.
    b2b = 1; last_acc = -1;
    for (int i = 0; i < 4; i++) send(rnd64(), 1);
    in_valid = 0;
    drain();
    b2b = 0;
    chk("queues_empty", 64'(exp_q.size() + lat_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
